// File: rtl/jtag_scan_pkg.sv
// Shared types and constants for the virtual-JTAG scan master.
package jtag_scan_pkg;

    // Virtual JTAG states visited by one command; IDLE means no scan in progress.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RTI  = 3'd5
    } scan_state_e;

    // Nios II debug slave virtual instruction codes.
    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    // Debug slave sr/jdo length.
    localparam int DEF_DR_WIDTH = 38;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: TCK_DIV clks low then TCK_DIV clks high while run is set.
// fall_en/rise_en are high in the clk whose closing edge drives TCK low/high,
// so any flop updated on that pulse changes together with the TCK edge.
// The first low half starts the clk after run rises (TCK is already low).
module jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic fall_en,
    output logic rise_en
);

    localparam int CW = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
    localparam logic [CW-1:0] CNT_RISE = CW'(TCK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * TCK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;

    // Phase counter and TCK level; both collapse to zero when not running.
    always_comb begin
        cnt_d   = '0;
        tck_d   = 1'b0;
        rise_en = run && (cnt_q == CNT_RISE);
        fall_en = run && (cnt_q == CNT_LAST);
        if (run) begin
            cnt_d = fall_en ? '0 : cnt_q + 1'b1;
            if (rise_en) begin
                tck_d = 1'b1;
            end else if (fall_en) begin
                tck_d = 1'b0;
            end else begin
                tck_d = tck_q;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck = tck_q;

endmodule

// File: rtl/jtag_debug_scan_master.sv
// Host-side initiator for the Nios II debug slave's virtual-JTAG port.
// One command = optional UIR, CDR, DR_WIDTH-bit SDR, UDR, RTI dwell; the
// bits shifted out by the slave are returned in rsp_data.
module jtag_debug_scan_master
    import jtag_scan_pkg::*;
#(
    parameter int DR_WIDTH   = DEF_DR_WIDTH,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic                cmd_ir_update,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int BW = $clog2(DR_WIDTH + 1);
    localparam int RW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);
    localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

    scan_state_e         state_q, state_d;
    logic [DR_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DR_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]       rti_cnt_q, rti_cnt_d;
    logic                tdi_q, tdi_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic                run;
    logic                fall_en;
    logic                rise_en;

    assign run = (state_q != IDLE);

    jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .tck     (vji_tck),
        .fall_en (fall_en),
        .rise_en (rise_en)
    );

    // Scan sequencing, TDI launch on falling TCK and TDO capture on rising TCK.
    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rsp_data_d  = rsp_data_q;
        ir_d        = ir_q;
        bit_cnt_d   = bit_cnt_q;
        rti_cnt_d   = rti_cnt_q;
        tdi_d       = tdi_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                // The accept edge itself acts as the first TCK fall.
                if (cmd_valid) begin
                    state_d = cmd_ir_update ? UIR : CDR;
                    tx_sr_d = cmd_data;
                    if (cmd_ir_update) begin
                        ir_d = cmd_ir;
                    end
                end
            end
            UIR: begin
                if (fall_en) begin
                    state_d = CDR;
                end
            end
            CDR: begin
                if (fall_en) begin
                    state_d   = SDR;
                    bit_cnt_d = '0;
                end
            end
            SDR: begin
                if (fall_en) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = UDR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            UDR: begin
                if (fall_en) begin
                    state_d   = RTI;
                    rti_cnt_d = '0;
                end
            end
            RTI: begin
                if (fall_en) begin
                    if (rti_cnt_q == RTI_LAST) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rx_sr_q;
                    end else begin
                        rti_cnt_d = rti_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Each fall that lands in SDR presents the next LSB; any other fall parks TDI low.
        if (fall_en) begin
            if (state_d == SDR) begin
                tdi_d   = tx_sr_q[0];
                tx_sr_d = {1'b0, tx_sr_q[DR_WIDTH-1:1]};
            end else begin
                tdi_d = 1'b0;
            end
        end

        // Sampled on the edge that raises TCK, i.e. before the slave shifts its sr.
        if (rise_en && (state_q == SDR)) begin
            rx_sr_d = {vji_tdo, rx_sr_q[DR_WIDTH-1:1]};
        end
    end

    // Master state registers; reset aborts any scan in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rsp_data_q  <= '0;
            ir_q        <= '0;
            bit_cnt_q   <= '0;
            rti_cnt_q   <= '0;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rsp_data_q  <= rsp_data_d;
            ir_q        <= ir_d;
            bit_cnt_q   <= bit_cnt_d;
            rti_cnt_q   <= rti_cnt_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_q;
    assign vji_uir   = (state_q == UIR);
    assign vji_cdr   = (state_q == CDR);
    assign vji_sdr   = (state_q == SDR);
    assign vji_udr   = (state_q == UDR);
    assign vji_rti   = (state_q == RTI);

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// Directed bench for jtag_debug_scan_master: default instance against a
// loopback debug-slave model, plus a TCK_DIV=1/RTI_CYCLES=1 instance whose
// tdo is tied back to tdi.
module tb_jtag_debug_scan_master;
    import jtag_scan_pkg::*;

    localparam int DR = 38;
    localparam logic [DR-1:0] CAPTURE = 38'h3F_0000_0001;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // default instance
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_ir = 2'd0;
    logic          cmd_ir_update = 1'b0;
    logic [DR-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic [DR-1:0] rsp_data;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [1:0]    vji_ir_in;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic [4:0]    strb;

    // fast instance
    logic          f_cmd_valid = 1'b0;
    logic          f_cmd_ready;
    logic [1:0]    f_cmd_ir = 2'd0;
    logic          f_cmd_ir_update = 1'b0;
    logic [DR-1:0] f_cmd_data = '0;
    logic          f_rsp_valid;
    logic [DR-1:0] f_rsp_data;
    logic          f_tck, f_tdi, f_tdo;
    logic [1:0]    f_ir_in;
    logic          f_uir, f_cdr, f_sdr, f_udr, f_rti;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    jtag_debug_scan_master u_dut (
        .clk (clk), .reset (reset),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_ir (cmd_ir),
        .cmd_ir_update (cmd_ir_update), .cmd_data (cmd_data),
        .rsp_valid (rsp_valid), .rsp_data (rsp_data),
        .vji_tck (vji_tck), .vji_tdi (vji_tdi), .vji_tdo (vji_tdo), .vji_ir_in (vji_ir_in),
        .vji_uir (vji_uir), .vji_cdr (vji_cdr), .vji_sdr (vji_sdr),
        .vji_udr (vji_udr), .vji_rti (vji_rti)
    );

    jtag_debug_scan_master #(
        .DR_WIDTH (DR), .IR_WIDTH (2), .TCK_DIV (1), .RTI_CYCLES (1)
    ) u_dut_fast (
        .clk (clk), .reset (reset),
        .cmd_valid (f_cmd_valid), .cmd_ready (f_cmd_ready), .cmd_ir (f_cmd_ir),
        .cmd_ir_update (f_cmd_ir_update), .cmd_data (f_cmd_data),
        .rsp_valid (f_rsp_valid), .rsp_data (f_rsp_data),
        .vji_tck (f_tck), .vji_tdi (f_tdi), .vji_tdo (f_tdo), .vji_ir_in (f_ir_in),
        .vji_uir (f_uir), .vji_cdr (f_cdr), .vji_sdr (f_sdr),
        .vji_udr (f_udr), .vji_rti (f_rti)
    );

    assign strb  = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
    assign f_tdo = f_tdi;

    // Debug-slave model: TCK-domain sr/ir, tdo = sr[0].
    logic [DR-1:0] slv_sr = '0;
    logic [1:0]    slv_ir = 2'd0;
    assign vji_tdo = slv_sr[0];
    always @(posedge vji_tck) begin
        if (vji_uir) slv_ir <= vji_ir_in;
        if (vji_cdr) slv_sr <= CAPTURE;
        else if (vji_sdr) slv_sr <= {vji_tdi, slv_sr[DR-1:1]};
    end

    // Cycle index = number of posedges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling clk edge.
    int            acc_cnt = 0;
    int            acc_cyc = 0;
    int            rsp_cnt = 0;
    int            uir_clks = 0;
    logic [DR-1:0] sr_at_udr = '0;
    int            f_sdr_clks = 0;
    int            f_sdr_rises = 0;
    int            f_tdi_bad = 0;
    logic          f_prev_tck = 1'b0;
    logic          f_prev_tdi = 1'b0;
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            acc_cnt = acc_cnt + 1;
            acc_cyc = cyc + 1;
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
        if (vji_uir) uir_clks = uir_clks + 1;
        if (vji_udr) sr_at_udr = slv_sr;
        if (f_sdr) begin
            f_sdr_clks = f_sdr_clks + 1;
            if (f_tck && !f_prev_tck) begin
                f_sdr_rises = f_sdr_rises + 1;
                if (f_tdi !== f_prev_tdi) f_tdi_bad = f_tdi_bad + 1;
            end
        end
        f_prev_tck = f_tck;
        f_prev_tdi = f_tdi;
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one command for a single clk; returns the accept edge index.
    task automatic start_scan(input logic [1:0] ir, input logic upd, input logic [DR-1:0] d,
                              output int t_acc);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_ir = ir; cmd_ir_update = upd; cmd_data = d;
        @(posedge clk); #1;
        t_acc = cyc;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid; returns at that negedge with its edge index.
    task automatic wait_rsp(input string tag, output int t_rsp);
        int i;
        i = 0;
        @(negedge clk);
        while (!rsp_valid && i < 1000) begin
            @(negedge clk);
            i = i + 1;
        end
        check_vec(tag, 64'(rsp_valid), 64'd1);
        t_rsp = cyc;
        $display("scan done: rsp_data=%h ir_in=%0d at cycle %0d", rsp_data, vji_ir_in, cyc);
    endtask

    int t_acc, t_rsp, t_rsp2, u0, a0, r0, s0, k0, b0, i;

    initial begin
        // 1: reset state
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_vec("rst_ready",  64'(cmd_ready), 64'd1);
        check_vec("rst_rspv",   64'(rsp_valid), 64'd0);
        check_vec("rst_rspd",   64'(rsp_data),  64'd0);
        check_vec("rst_tck",    64'(vji_tck),   64'd0);
        check_vec("rst_tdi",    64'(vji_tdi),   64'd0);
        check_vec("rst_strb",   64'(strb),      64'd0);
        check_vec("rst_ir",     64'(vji_ir_in), 64'd0);

        // 2: full scan with IR update
        u0 = uir_clks;
        start_scan(IR_BREAK, 1'b1, 38'h15_5555_5555, t_acc);
        $display("scan start: ir=2 upd=1 data=%h at cycle %0d", 38'h15_5555_5555, t_acc);
        wait_rsp("s2_timeout", t_rsp);
        check_vec("s2_rspd",    64'(rsp_data),        64'(CAPTURE));
        check_vec("s2_slv_sr",  64'(sr_at_udr),       64'h15_5555_5555);
        check_vec("s2_slv_ir",  64'(slv_ir),          64'd2);
        check_vec("s2_ir_in",   64'(vji_ir_in),       64'd2);
        check_vec("s2_latency", 64'(t_rsp - t_acc),   64'd176);
        check_vec("s2_uir_len", 64'(uir_clks - u0),   64'd4);
        check_vec("s2_ready",   64'(cmd_ready),       64'd1);
        @(negedge clk);
        check_vec("s2_pulse",   64'(rsp_valid),       64'd0);

        // 3: same scan without IR update
        u0 = uir_clks;
        start_scan(IR_OCIMEM, 1'b0, 38'h15_5555_5555, t_acc);
        $display("scan start: ir=0 upd=0 data=%h at cycle %0d", 38'h15_5555_5555, t_acc);
        wait_rsp("s3_timeout", t_rsp);
        check_vec("s3_no_uir",  64'(uir_clks - u0),   64'd0);
        check_vec("s3_ir_in",   64'(vji_ir_in),       64'd2);
        check_vec("s3_latency", 64'(t_rsp - t_acc),   64'd172);
        check_vec("s3_rspd",    64'(rsp_data),        64'(CAPTURE));

        // 4: fast instance, tdo looped back to tdi
        s0 = f_sdr_clks; k0 = f_sdr_rises; b0 = f_tdi_bad;
        @(posedge clk); #1;
        f_cmd_valid = 1'b1; f_cmd_ir = IR_TRACEMEM; f_cmd_ir_update = 1'b1; f_cmd_data = 38'h2A_C3A5_0F96;
        @(posedge clk); #1;
        t_acc = cyc;
        f_cmd_valid = 1'b0;
        i = 0;
        @(negedge clk);
        while (!f_rsp_valid && i < 1000) begin
            @(negedge clk);
            i = i + 1;
        end
        $display("fast scan done: rsp_data=%h at cycle %0d", f_rsp_data, cyc);
        check_vec("s4_timeout", 64'(f_rsp_valid),         64'd1);
        check_vec("s4_sdr_clk", 64'(f_sdr_clks - s0),     64'd76);
        check_vec("s4_rises",   64'(f_sdr_rises - k0),    64'd38);
        check_vec("s4_tdi_chg", 64'(f_tdi_bad - b0),      64'd0);
        check_vec("s4_latency", 64'(cyc - t_acc),         64'd84);
        check_vec("s4_loopbk",  64'(f_rsp_data),          64'h2A_C3A5_0F96);

        // 5: cmd_valid held through a busy scan
        a0 = acc_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_ir = IR_BREAK; cmd_ir_update = 1'b1; cmd_data = 38'h01_2345_6789;
        @(posedge clk); #1;
        cmd_ir = IR_OCIMEM; cmd_data = 38'h3E_DCBA_9876;
        wait_rsp("s5_timeout1", t_rsp);
        check_vec("s5_rspd1",   64'(rsp_data),  64'(CAPTURE));
        check_vec("s5_slv_sr1", 64'(sr_at_udr), 64'h01_2345_6789);
        check_vec("s5_ir_in1",  64'(vji_ir_in), 64'd2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_vec("s5_acc_cnt", 64'(acc_cnt - a0), 64'd2);
        check_vec("s5_acc_cyc", 64'(acc_cyc),      64'(t_rsp + 1));
        check_vec("s5_busy",    64'(cmd_ready),    64'd0);
        wait_rsp("s5_timeout2", t_rsp2);
        check_vec("s5_slv_sr2", 64'(sr_at_udr), 64'h3E_DCBA_9876);
        check_vec("s5_ir_in2",  64'(vji_ir_in), 64'd0);

        // 6: reset during SDR bit 20, then a clean scan
        start_scan(IR_TRACEMEM, 1'b1, 38'h0F_F00F_F00F, t_acc);
        i = 0;
        while (!vji_sdr && i < 100) begin
            @(negedge clk);
            i = i + 1;
        end
        repeat (20 * 4) @(negedge clk);
        check_vec("s6_in_sdr", 64'(vji_sdr), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        $display("reset applied mid-scan at cycle %0d", cyc);
        check_vec("s6_ready",  64'(cmd_ready), 64'd1);
        check_vec("s6_rspv",   64'(rsp_valid), 64'd0);
        check_vec("s6_rspd",   64'(rsp_data),  64'd0);
        check_vec("s6_tck",    64'(vji_tck),   64'd0);
        check_vec("s6_tdi",    64'(vji_tdi),   64'd0);
        check_vec("s6_strb",   64'(strb),      64'd0);
        check_vec("s6_ir",     64'(vji_ir_in), 64'd0);
        r0 = rsp_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check_vec("s6_no_rsp", 64'(rsp_cnt - r0), 64'd0);
        check_vec("s6_idle_tck", 64'(vji_tck),    64'd0);
        start_scan(IR_TRACECTRL, 1'b1, 38'h33_CCCC_3333, t_acc);
        wait_rsp("s6_timeout", t_rsp);
        check_vec("s6_rspd2",   64'(rsp_data),      64'(CAPTURE));
        check_vec("s6_slv_sr",  64'(sr_at_udr),     64'h33_CCCC_3333);
        check_vec("s6_slv_ir",  64'(slv_ir),        64'd3);
        check_vec("s6_latency", 64'(t_rsp - t_acc), 64'd176);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case a bounded wait is somehow bypassed.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
        $fatal(1, "watchdog");
    end

endmodule
